// File: rtl/bps_pkg.sv
// Shared BP-S definitions: opcode values driven by the sequencer and the slave FSM encoding.
package bps_pkg;

  localparam logic [2:0] OP_IDLE       = 3'd0;
  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_DOWN       = 3'd2;
  localparam logic [2:0] OP_UP         = 3'd3;
  localparam logic [2:0] OP_STORE_DOWN = 3'd4;
  localparam logic [2:0] OP_STORE_UP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SWEEP = 3'd2,
    S_STORE = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/bps_if.sv
// BP-S bundle: sequencer opcode/stall/err plus the message-memory req/gnt/rvalid port.
interface bps_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic [2:0]        bps_opcode;
  logic              bps_stall;
  logic              bps_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  bps_opcode, mem_gnt, mem_rvalid, mem_rdata,
    output bps_stall, bps_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output bps_opcode, mem_gnt, mem_rvalid, mem_rdata,
    input  bps_stall, bps_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bps_msg_ram.sv
// Local message buffer: one write port, one read port with a registered (1-cycle) read.
module bps_msg_ram #(
  parameter  int DATA_W = 16,
  parameter  int NODES  = 64,
  localparam int AW     = $clog2(NODES)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [NODES];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bps_slave.sv
// BP-S opcode executor: loads, prefix/suffix-sweeps (saturating) and stores a NODES-word
// message buffer over a req/gnt memory port.
module bps_slave
  import bps_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NODES     = 64,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 'h0000,
  parameter logic [ADDR_W-1:0] DOWN_BASE = 'h1000,
  parameter logic [ADDR_W-1:0] UP_BASE   = 'h2000
) (
  input logic  clk,
  input logic  rst_n,
  bps_if.slave bus
);
  localparam int IW = $clog2(NODES);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST = idx_t'(NODES - 1);

  state_e            state_q;
  logic              stall_q, err_q, req_q, we_q, setup_q, up_q;
  idx_t              cnt_q, rcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] acc_q;

  logic              ram_we;
  idx_t              ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W:0]   sum_d;
  logic [DATA_W-1:0] sat_d;
  logic              xfer;

  function automatic idx_t sweep_idx(idx_t i, logic up);
    return up ? (LAST - i) : i;
  endfunction

  assign xfer  = req_q & bus.mem_gnt;
  assign sum_d = {1'b0, acc_q} + {1'b0, ram_rdata};
  assign sat_d = sum_d[DATA_W] ? {DATA_W{1'b1}} : sum_d[DATA_W-1:0];

  // During a sweep the read runs one index ahead of the write-back of the previous word.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    case (state_q)
      S_LOAD: begin
        ram_we    = bus.mem_rvalid;
        ram_waddr = rcnt_q;
        ram_wdata = bus.mem_rdata;
      end
      S_SWEEP: begin
        ram_we    = ~setup_q;
        ram_waddr = sweep_idx(cnt_q, up_q);
        ram_wdata = sat_d;
        ram_raddr = setup_q ? sweep_idx(idx_t'(0), up_q) : sweep_idx(cnt_q + idx_t'(1), up_q);
      end
      S_STORE: ram_raddr = xfer ? (cnt_q + idx_t'(1)) : cnt_q;
      default: ;
    endcase
  end

  bps_msg_ram #(.DATA_W(DATA_W), .NODES(NODES)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      setup_q <= 1'b0;
      up_q    <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      if (bus.bps_opcode != OP_IDLE && (stall_q || bus.bps_opcode > OP_STORE_UP))
        err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          case (bus.bps_opcode)
            OP_LOAD: begin
              state_q <= S_LOAD;
              stall_q <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= LOAD_BASE;
              cnt_q   <= '0;
              rcnt_q  <= '0;
            end
            OP_DOWN, OP_UP: begin
              state_q <= S_SWEEP;
              stall_q <= 1'b1;
              setup_q <= 1'b1;
              up_q    <= (bus.bps_opcode == OP_UP);
              cnt_q   <= '0;
              acc_q   <= '0;
            end
            OP_STORE_DOWN, OP_STORE_UP: begin
              state_q <= S_STORE;
              stall_q <= 1'b1;
              setup_q <= 1'b1;
              we_q    <= 1'b1;
              cnt_q   <= '0;
              addr_q  <= (bus.bps_opcode == OP_STORE_UP) ? UP_BASE : DOWN_BASE;
            end
            default: ;
          endcase
        end
        S_LOAD: begin
          if (xfer) begin
            if (cnt_q == LAST) req_q <= 1'b0;
            else begin
              cnt_q  <= cnt_q + idx_t'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
          if (bus.mem_rvalid) begin
            if (rcnt_q == LAST) begin
              state_q <= S_IDLE;
              stall_q <= 1'b0;
            end else rcnt_q <= rcnt_q + idx_t'(1);
          end
        end
        S_SWEEP: begin
          if (setup_q) setup_q <= 1'b0;
          else begin
            acc_q <= sat_d;
            if (cnt_q == LAST) state_q <= S_DRAIN;
            else cnt_q <= cnt_q + idx_t'(1);
          end
        end
        S_STORE: begin
          // The setup cycle primes the buffer read so write data is valid when req rises.
          if (setup_q) begin
            setup_q <= 1'b0;
            req_q   <= 1'b1;
          end else if (xfer) begin
            if (cnt_q == LAST) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              cnt_q  <= cnt_q + idx_t'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bps_stall = stall_q;
  assign bus.bps_err   = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (req_q && we_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_bps_slave.sv
// Self-checking bench for bps_slave: random-grant/latency memory model plus a behavioural
// buffer model computing prefix/suffix saturating sums.
module tb_bps_slave;
  import bps_pkg::*;

  localparam int N     = 4;
  localparam int LBASE = 'h0000;
  localparam int DBASE = 'h1000;
  localparam int UBASE = 'h2000;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bps_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  bps_slave #(.DATA_W(16), .NODES(N), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // External memory model
  logic [15:0] mem [65536];
  typedef struct { logic [15:0] d; int rdy; } rsp_t;
  rsp_t rq[$];
  int   cyc    = 0;
  int   wr_cnt = 0;

  always @(posedge clk) begin
    rsp_t r;
    cyc++;
    if (!rst_n) rq.delete();
    else if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
        wr_cnt++;
      end else begin
        r.d   = mem[bus.mem_addr];
        r.rdy = cyc + $urandom_range(0, 3);
        if (rq.size() > 0 && r.rdy < rq[$].rdy) r.rdy = rq[$].rdy;
        rq.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    bus.mem_gnt = ($urandom_range(0, 2) != 0);
    if (rst_n && rq.size() > 0 && rq[0].rdy <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rq[0].d;
      void'(rq.pop_front());
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'($urandom);
    end
  end

  // Behavioural buffer model
  logic [15:0] model_buf [N];

  function automatic void model_sweep(bit up);
    int acc = 0;
    for (int k = 0; k < N; k++) begin
      int i = up ? (N - 1 - k) : k;
      acc = acc + int'(model_buf[i]);
      if (acc > 65535) acc = 65535;
      model_buf[i] = 16'(acc);
    end
  endfunction

  task automatic preload(input logic [15:0] v [N]);
    for (int i = 0; i < N; i++) begin
      mem[LBASE + i] = v[i];
      model_buf[i]   = v[i];
    end
  endtask

  task automatic run_op(input logic [2:0] op, output int cycles, output bit tmo);
    @(negedge clk);
    bus.bps_opcode = op;
    @(negedge clk);
    bus.bps_opcode = OP_IDLE;
    cycles = 0;
    while (bus.bps_stall === 1'b1 && cycles < TMO) begin
      cycles++;
      @(negedge clk);
    end
    tmo = (cycles >= TMO);
    $display("op=%0d stall_cycles=%0d err=%0b", op, cycles, bus.bps_err);
  endtask

  // Scramble the destination so an unwritten word cannot match, then store.
  task automatic do_store(input logic [2:0] op, output int cycles, output bit tmo);
    int base = (op == OP_STORE_UP) ? UBASE : DBASE;
    for (int i = 0; i < N; i++) mem[base + i] = ~model_buf[i];
    wr_cnt = 0;
    run_op(op, cycles, tmo);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.bps_stall, bus.mem_req, bus.bps_err} !== 3'b000)
      $display("FAIL reset_hold stall/req/err=%b required 000",
               {bus.bps_stall, bus.mem_req, bus.bps_err});
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.bps_stall, bus.mem_req, bus.bps_err} !== 3'b000)
        $display("FAIL idle_c%0d stall/req/err=%b required 000", c,
                 {bus.bps_stall, bus.mem_req, bus.bps_err});
      else n_pass++;
    end
  endtask

  task automatic test_down_store;
    int cy; bit tmo;
    logic [15:0] v [N] = '{16'd1, 16'd2, 16'd3, 16'd4};
    preload(v);
    run_op(OP_LOAD, cy, tmo);
    n_checks++;
    if (tmo) $display("FAIL down_load_timeout cycles=%0d required <%0d", cy, TMO);
    else n_pass++;
    run_op(OP_DOWN, cy, tmo);
    model_sweep(1'b0);
    n_checks++;
    if (cy != N + 2) $display("FAIL down_stall_len got %0d required %0d", cy, N + 2);
    else n_pass++;
    do_store(OP_STORE_DOWN, cy, tmo);
    n_checks++;
    if (tmo || wr_cnt != N) $display("FAIL down_store_writes got %0d required %0d", wr_cnt, N);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[DBASE + i] !== model_buf[i])
        $display("FAIL down_mem[%0d] got %h required %h", i, mem[DBASE + i], model_buf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_up_store;
    int cy; bit tmo;
    logic [15:0] v [N] = '{16'd1, 16'd2, 16'd3, 16'd4};
    preload(v);
    run_op(OP_LOAD, cy, tmo);
    run_op(OP_UP, cy, tmo);
    model_sweep(1'b1);
    n_checks++;
    if (cy != N + 2) $display("FAIL up_stall_len got %0d required %0d", cy, N + 2);
    else n_pass++;
    do_store(OP_STORE_UP, cy, tmo);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[UBASE + i] !== model_buf[i])
        $display("FAIL up_mem[%0d] got %h required %h", i, mem[UBASE + i], model_buf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation;
    int cy; bit tmo;
    logic [15:0] v [N] = '{16'hFFFF, 16'd1, 16'd0, 16'd0};
    preload(v);
    run_op(OP_LOAD, cy, tmo);
    run_op(OP_DOWN, cy, tmo);
    model_sweep(1'b0);
    do_store(OP_STORE_DOWN, cy, tmo);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[DBASE + i] !== model_buf[i])
        $display("FAIL sat_mem[%0d] got %h required %h", i, mem[DBASE + i], model_buf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int cy; bit tmo;
    for (int it = 0; it < 6; it++) begin
      logic [15:0] v [N];
      int sw, base;
      logic [2:0] st;
      for (int k = 0; k < N; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(30000, 65535))
                                           : 16'($urandom_range(0, 9000));
      sw = $urandom_range(0, 2);
      st = ($urandom_range(0, 1) == 1) ? OP_STORE_UP : OP_STORE_DOWN;
      base = (st == OP_STORE_UP) ? UBASE : DBASE;
      preload(v);
      run_op(OP_LOAD, cy, tmo);
      if (sw != 0) begin
        run_op((sw == 2) ? OP_UP : OP_DOWN, cy, tmo);
        model_sweep(sw == 2);
        n_checks++;
        if (cy != N + 2) $display("FAIL rand%0d_stall_len got %0d required %0d", it, cy, N + 2);
        else n_pass++;
      end
      do_store(st, cy, tmo);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (mem[base + i] !== model_buf[i])
          $display("FAIL rand%0d_mem[%0d] got %h required %h", it, i, mem[base + i], model_buf[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_busy_err;
    int cy; bit tmo;
    logic [15:0] v [N];
    for (int k = 0; k < N; k++) v[k] = 16'($urandom_range(1, 60000));
    preload(v);
    n_checks++;
    if (bus.bps_err !== 1'b0) $display("FAIL err_pre got %b required 0", bus.bps_err);
    else n_pass++;
    @(negedge clk);
    bus.bps_opcode = OP_LOAD;
    @(negedge clk);
    bus.bps_opcode = OP_DOWN;
    @(negedge clk);
    bus.bps_opcode = OP_IDLE;
    cy = 0;
    while (bus.bps_stall === 1'b1 && cy < TMO) begin
      cy++;
      @(negedge clk);
    end
    $display("op=LOAD+busy_DOWN stall_cycles=%0d err=%0b", cy, bus.bps_err);
    n_checks++;
    if (bus.bps_err !== 1'b1) $display("FAIL err_busy got %b required 1", bus.bps_err);
    else n_pass++;
    // No sweep ran, so the stored buffer must equal what was loaded.
    do_store(OP_STORE_DOWN, cy, tmo);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[DBASE + i] !== model_buf[i])
        $display("FAIL busy_mem[%0d] got %h required %h", i, mem[DBASE + i], model_buf[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.bps_err !== 1'b1) $display("FAIL err_sticky got %b required 1", bus.bps_err);
    else n_pass++;

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.bps_err !== 1'b0) $display("FAIL err_reset got %b required 0", bus.bps_err);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    bus.bps_opcode = 3'd7;
    @(negedge clk);
    bus.bps_opcode = OP_IDLE;
    $display("op=7 stall=%0b err=%0b", bus.bps_stall, bus.bps_err);
    n_checks++;
    if ({bus.bps_stall, bus.bps_err} !== 2'b01)
      $display("FAIL op7 stall/err=%b required 01", {bus.bps_stall, bus.bps_err});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.bps_stall !== 1'b0) $display("FAIL op7_stall_late got %b required 0", bus.bps_stall);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store;
    int cy, n; bit tmo;
    logic [15:0] v [N];
    for (int k = 0; k < N; k++) v[k] = 16'($urandom);
    preload(v);
    run_op(OP_LOAD, cy, tmo);
    wr_cnt = 0;
    @(negedge clk);
    bus.bps_opcode = OP_STORE_UP;
    @(negedge clk);
    bus.bps_opcode = OP_IDLE;
    n = 0;
    while (wr_cnt < 2 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= TMO) $display("FAIL midstore_wait writes=%0d required 2", wr_cnt);
    else n_pass++;
    n_checks++;
    if ({bus.mem_req, bus.bps_stall} !== 2'b11)
      $display("FAIL midstore_busy req/stall=%b required 11", {bus.mem_req, bus.bps_stall});
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    $display("op=RESET_MID_STORE writes=%0d req=%0b stall=%0b", wr_cnt, bus.mem_req, bus.bps_stall);
    n_checks++;
    if ({bus.mem_req, bus.bps_stall, bus.bps_err} !== 3'b000)
      $display("FAIL async_reset req/stall/err=%b required 000",
               {bus.mem_req, bus.bps_stall, bus.bps_err});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) v[k] = 16'($urandom_range(0, 20000));
    preload(v);
    run_op(OP_LOAD, cy, tmo);
    n_checks++;
    if (tmo) $display("FAIL post_reset_load cycles=%0d required <%0d", cy, TMO);
    else n_pass++;
    run_op(OP_DOWN, cy, tmo);
    model_sweep(1'b0);
    do_store(OP_STORE_DOWN, cy, tmo);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[DBASE + i] !== model_buf[i])
        $display("FAIL post_reset_mem[%0d] got %h required %h", i, mem[DBASE + i], model_buf[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.bps_opcode = OP_IDLE;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_down_store();
    test_up_store();
    test_saturation();
    test_random();
    test_busy_err();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
